// File: rtl/sorter_8_arbiter.sv
`ifndef ARR_8_FLAT_WIDTH
`define ARR_8_FLAT_WIDTH 128
`endif
// Purpose: shares one sorter_8 pipeline between two requesters using round-robin issue and an in-order owner tag FIFO.
// Latency: the grant is combinational (req_ready in the accept cycle); a result reaches resp_valid 6 cycles after accept when not stalled.
// Backpressure: if the head owner's resp_ready is low, the whole sorter stalls and no new block issues (head-of-line blocking).
// Ports:
//   clock, reset_n                      : clock, asynchronous active-low reset
//   req_valid/ready/asc, req_data0/1    : per-requester block offer (bit i = requester i)
//   resp_valid/ready, resp_data         : per-requester result handshake, shared data bus
//   srt_*                               : connection to the single sorter_8 instance
//   busy, done_cnt0/1, err              : blocks in flight, wrapping delivery counters, sticky orphan-result flag
module sorter_8_arbiter #(
    parameter int W         = `ARR_8_FLAT_WIDTH,
    parameter int TAG_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_asc,
    input  logic [W-1:0]     req_data0,
    input  logic [W-1:0]     req_data1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [W-1:0]     resp_data,
    output logic             srt_valid_in,
    output logic             srt_asc_in,
    output logic             srt_stall_in,
    output logic [W-1:0]     srt_pairs_in_flat,
    input  logic             srt_valid_out,
    input  logic [W-1:0]     srt_pairs_out_flat,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1,
    output logic             err
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    // Tags are single-bit requester IDs, so the FIFO storage is a packed vector.
    logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        tag_count_q, tag_count_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     done_cnt0_q, done_cnt0_d;
    logic [CNT_W-1:0]     done_cnt1_q, done_cnt1_d;
    logic                 err_q, err_d;

    logic       tags_nonempty;
    logic       head;
    logic       resp_act;
    logic       stall;
    logic       pop;
    logic       push;
    logic       issue_ok;
    logic       granted_id;
    logic [1:0] grant;

    assign tags_nonempty = (tag_count_q != '0);
    assign head          = tag_mem_q[rd_ptr_q];
    // A sorter output only counts as a response when some block is owed to a requester.
    assign resp_act      = srt_valid_out && tags_nonempty;
    assign stall         = resp_act && !resp_ready[head];
    assign pop           = resp_act && resp_ready[head];
    // reset_n gating keeps req_ready/srt_valid_in low while reset is held.
    assign issue_ok      = reset_n && !stall && (tag_count_q < CW'(TAG_DEPTH));

    always_comb begin
        grant = 2'b00;
        if (issue_ok) begin
            if (req_valid[0] && (!rr_ptr_q || !req_valid[1])) begin
                grant[0] = 1'b1;
            end else if (req_valid[1] && (rr_ptr_q || !req_valid[0])) begin
                grant[1] = 1'b1;
            end
        end
    end

    assign granted_id        = grant[1];
    assign push              = |grant;
    assign req_ready         = grant;
    assign srt_valid_in      = push;
    assign srt_asc_in        = granted_id ? req_asc[1] : req_asc[0];
    assign srt_pairs_in_flat = granted_id ? req_data1 : req_data0;
    assign srt_stall_in      = stall;

    assign resp_valid = resp_act ? (head ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data  = srt_pairs_out_flat;
    assign busy       = tags_nonempty;
    assign done_cnt0  = done_cnt0_q;
    assign done_cnt1  = done_cnt1_q;
    assign err        = err_q;

    always_comb begin
        tag_mem_d   = tag_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_count_d = tag_count_q;
        rr_ptr_d    = rr_ptr_q;
        done_cnt0_d = done_cnt0_q;
        done_cnt1_d = done_cnt1_q;
        err_d       = err_q;

        if (push) begin
            tag_mem_d[wr_ptr_q] = granted_id;
            wr_ptr_d            = wr_ptr_q + PW'(1);
            rr_ptr_d            = ~granted_id;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (head) begin
                done_cnt1_d = done_cnt1_q + CNT_W'(1);
            end else begin
                done_cnt0_d = done_cnt0_q + CNT_W'(1);
            end
        end
        if (push && !pop) begin
            tag_count_d = tag_count_q + CW'(1);
        end else if (pop && !push) begin
            tag_count_d = tag_count_q - CW'(1);
        end
        // Orphan sorter output: flag it, but neither respond nor stall.
        if (srt_valid_out && !tags_nonempty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_mem_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_count_q <= '0;
            rr_ptr_q    <= 1'b0;
            done_cnt0_q <= '0;
            done_cnt1_q <= '0;
            err_q       <= 1'b0;
        end else begin
            tag_mem_q   <= tag_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_count_q <= tag_count_d;
            rr_ptr_q    <= rr_ptr_d;
            done_cnt0_q <= done_cnt0_d;
            done_cnt1_q <= done_cnt1_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: doc/sorter_8_arbiter.md
Name: sorter_8_arbiter

Overview:
- Shares one 8-pair sorter_8 pipeline between two requesters. Each requester offers one 8-pair block with its own sort direction.
- Round-robin arbitration picks the winner. Each issued block's requester ID goes into an in-order tag FIFO, so every sorted result returns to its owner.
- Drives the sorter's stall_in from the owning requester's backpressure.
- Sits between the aoc5 merge/partition stages and the single sorter_8 instance.

Parameters:
- W, `ARR_8_FLAT_WIDTH, flat width of one 8-pair block.
- TAG_DEPTH, 8, tag FIFO entries; must be ≥ 6 (sorter occupancy); power of 2.
- CNT_W, 16, width of the per-requester completion counters.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_asc  in  2  sort direction per requester, 1 = ascending
- req_data0  in  W  requester 0 block
- req_data1  in  W  requester 1 block
- resp_valid  out  2  sorted block available for requester i
- resp_ready  in  2  requester i can take its result
- resp_data  out  W  sorted block, shared by both requesters, qualified by resp_valid
- srt_valid_in  out  1  to sorter valid_in
- srt_asc_in  out  1  to sorter asc_in
- srt_stall_in  out  1  to sorter stall_in
- srt_pairs_in_flat  out  W  to sorter pairs_in_flat
- srt_valid_out  in  1  from sorter valid_out
- srt_pairs_out_flat  in  W  from sorter pairs_out_flat
- busy  out  1  blocks in flight (tag FIFO non-empty)
- done_cnt0, done_cnt1  out  CNT_W  results delivered per requester, wrapping
- err  out  1  sticky: sorter produced valid_out with tag FIFO empty

Behaviour:
- Reset (async, reset_n=0): req_ready=0, resp_valid=0, srt_valid_in=0, srt_stall_in=0, rr_ptr=0, tag FIFO empty, done_cnt*=0, err=0, busy=0.
- Reset sequencing: top level asserts the sorter's reset in the same cycles. In-flight blocks are discarded.
- Sorter timing: sorter_8 latency is 6 cycles unstalled. Its stage-1 hold is internal, so input is guaranteed to load only when srt_stall_in=0.
- Issue condition (combinational): issue_ok = !srt_stall_in && tag_count < TAG_DEPTH.
- Arbitration:
  - Grant requester i when issue_ok && req_valid[i] && (rr_ptr==i || !req_valid[other]).
  - req_ready = grant, one-hot.
  - srt_valid_in = |grant.
  - srt_pairs_in_flat and srt_asc_in are muxed from the granted requester.
  - When no grant, srt_valid_in=0 and data is don't-care.
- Round-robin: rr_ptr <= ~granted_id on any grant; holds otherwise.
- Requester rule: req_valid, req_asc and data must stay stable until req_ready.
- Tag FIFO:
  - Push granted_id on issue.
  - head = oldest tag.
  - Pop on srt_valid_out && resp_ready[head].
  - Simultaneous push and pop leaves tag_count unchanged.
- Response:
  - resp_valid[head] = srt_valid_out && tag_count != 0; the other bit is 0.
  - resp_data = srt_pairs_out_flat.
  - Latency accept→resp_valid is 6 cycles with no backpressure.
- Backpressure: srt_stall_in = srt_valid_out && tag_count != 0 && !resp_ready[head]. While stalled, no issue occurs.
- Counters: done_cnt[head] increments on each pop and wraps at 2^CNT_W.
- Error case: srt_valid_out=1 with tag_count==0 sets err, produces no response, and does not stall.
- Flow rate: one issue and one delivery per cycle sustained. Ordering is strictly in issue order; a stalled head blocks the other requester's results (head-of-line, by design).
- Size: about 150-250 lines RTL, including an instantiation-free tag FIFO (count + rd/wr pointers).

Test Plan:
- Single request: req_valid=01, asc=1, data = 8 shuffled pairs, resp_ready=11. Required: req_ready=01 same cycle; resp_valid=01 six cycles later with ascending data; done_cnt0=1; busy drops the cycle after.
- Both requesters held valid for 8 cycles: grants alternate 01,10,01,…. Results return in issue order to matching resp_valid bits; done_cnt0=done_cnt1=4.
- Mixed direction: req0 asc=1 and req1 asc=0 back-to-back with identical data. Required: resp0 gets ascending order, resp1 gets descending.
- Backpressure: fill the pipeline with 6 blocks from requester 1, then drop resp_ready[1] for 5 cycles. Required: srt_stall_in=1, req_ready=00, no data lost; after release, 6 results arrive on consecutive cycles.
- Async reset: assert reset_n=0 mid-stream with 4 in flight. Required: all outputs go to reset values immediately, with no resp_valid after release.
- Error: force srt_valid_out=1 with empty tag FIFO. Required: err=1 sticky, resp_valid=00.
